// File: rtl/up_counter_4b_pkg.sv
// Shared constants for the up_counter_4b family: the default width and
// the default terminal value derived from a width.
package up_counter_4b_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 4;

    // Largest value representable in 'width' bits, used as the default wrap point.
    function automatic int default_max_value(input int width);
        return (2 ** width) - 1;
    endfunction

endpackage

// File: rtl/up_counter_4b.sv
// Enable-gated binary up counter that wraps at MAX_VALUE, with a combinational
// terminal-count flag and a registered one-cycle wrap pulse.
module up_counter_4b
    import up_counter_4b_pkg::*;
#(
    parameter int WIDTH     = COUNTER_WIDTH_DEFAULT,
    parameter int MAX_VALUE = default_max_value(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VALUE);

    if (MAX_VALUE < 1 || MAX_VALUE > (2 ** WIDTH) - 1) begin : g_bad_max_value
        $error("up_counter_4b: MAX_VALUE %0d is outside 1..2**WIDTH-1 for WIDTH %0d",
               MAX_VALUE, WIDTH);
    end

    // Priority is reset, then enable, then hold; wrap is cleared on every
    // edge that is not an enabled rollover so it can never stretch.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (enable) begin
            if (count == MAX_CNT) begin
                count <= '0;
                wrap  <= 1'b1;
            end else begin
                count <= count + WIDTH'(1);
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    assign tc = (count == MAX_CNT);

endmodule

// File: tb/tb_up_counter_4b.sv
// Directed and randomized checks of up_counter_4b in its default build and
// in a decimal (MAX_VALUE=9) build, against a modulo-arithmetic reference.
module tb_up_counter_4b;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] count_16;
    logic       tc_16;
    logic       wrap_16;
    logic [3:0] count_10;
    logic       tc_10;
    logic       wrap_10;

    int n_checks;
    int n_fails;

    // Reference state: counter value and wrap flag for each build.
    int m_cnt_16, m_wrap_16;
    int m_cnt_10, m_wrap_10;

    int exp_dec[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    up_counter_4b dut_16 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (count_16),
        .tc     (tc_16),
        .wrap   (wrap_16)
    );

    up_counter_4b #(.WIDTH(4), .MAX_VALUE(9)) dut_10 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (count_10),
        .tc     (tc_10),
        .wrap   (wrap_10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Spec-level model: reset clears; an enabled edge advances modulo (max+1)
    // and flags wrap when the value it left was max; otherwise hold.
    function automatic void model_edge(input logic r, input logic e, input int max_v,
                                       inout int cnt, inout int wrp);
        if (r) begin
            cnt = 0;
            wrp = 0;
        end else if (e) begin
            wrp = (cnt == max_v) ? 1 : 0;
            cnt = (cnt + 1) % (max_v + 1);
        end else begin
            wrp = 0;
        end
    endfunction

    // Drive on the falling edge, sample 1 ns after the rising edge, compare both builds.
    task automatic step(input logic r, input logic e);
        @(negedge clk);
        reset  = r;
        enable = e;
        @(posedge clk);
        #1;
        model_edge(r, e, 15, m_cnt_16, m_wrap_16);
        model_edge(r, e, 9, m_cnt_10, m_wrap_10);
        check("count_16", 32'(count_16), 32'(m_cnt_16));
        check("tc_16",    32'(tc_16),    32'(m_cnt_16 == 15));
        check("wrap_16",  32'(wrap_16),  32'(m_wrap_16));
        check("count_10", 32'(count_10), 32'(m_cnt_10));
        check("tc_10",    32'(tc_10),    32'(m_cnt_10 == 9));
        check("wrap_10",  32'(wrap_10),  32'(m_wrap_10));
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        m_cnt_16  = 0;
        m_wrap_16 = 0;
        m_cnt_10  = 0;
        m_wrap_10 = 0;
        reset     = 1'b1;
        enable    = 1'b0;

        // Reset edge at 5 ns.
        @(posedge clk);
        #1;
        check("reset_count_16", 32'(count_16), 32'd0);
        check("reset_wrap_16",  32'(wrap_16),  32'd0);
        check("reset_tc_16",    32'(tc_16),    32'd0);
        check("reset_count_10", 32'(count_10), 32'd0);

        // Count up from 0; edges at 15..125 ns.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1);
            check("dec_sequence", 32'(count_10), 32'(exp_dec[i]));
            check("dec_tc", 32'(tc_10), 32'(exp_dec[i] == 9));
            check("dec_wrap", 32'(wrap_10), 32'(i == 9));
            check("early_wrap_16", 32'(wrap_16), 32'd0);
            if (i == 9) check("count_at_105ns", 32'(count_16), 32'd10);
        end

        // Reset mid-count with enable held high.
        check("pre_reset_12", 32'(count_16), 32'd12);
        step(1'b1, 1'b1);
        check("reset_mid_count", 32'(count_16), 32'd0);
        step(1'b0, 1'b1);
        check("after_reset_release", 32'(count_16), 32'd1);

        // Full wrap of the default build.
        step(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
        check("reach_15", 32'(count_16), 32'd15);
        check("tc_at_15", 32'(tc_16), 32'd1);
        step(1'b0, 1'b1);
        check("rollover_count", 32'(count_16), 32'd0);
        check("rollover_wrap", 32'(wrap_16), 32'd1);
        check("rollover_tc", 32'(tc_16), 32'd0);
        step(1'b0, 1'b1);
        check("wrap_one_cycle", 32'(wrap_16), 32'd0);
        check("count_after_wrap", 32'(count_16), 32'd1);

        // Hold at 7 for three edges.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        check("reach_7", 32'(count_16), 32'd7);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check("hold_count", 32'(count_16), 32'd7);
            check("hold_wrap", 32'(wrap_16), 32'd0);
        end
        step(1'b0, 1'b1);
        check("resume_8", 32'(count_16), 32'd8);

        // Reset and enable together at the terminal value.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
        check("reach_15_again", 32'(count_16), 32'd15);
        step(1'b1, 1'b1);
        check("reset_at_max_count", 32'(count_16), 32'd0);
        check("reset_at_max_wrap", 32'(wrap_16), 32'd0);

        // Randomized enable with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0));
            check("dec_bound", 32'(count_10 <= 4'd9), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        n_fails++;
        $display("FAIL timeout: observed no completion expected finish before 100000 ns");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/up_counter_4b.md
Name: up_counter_4b

Overview:
- Free-running, enable-gated binary up counter with synchronous active-high reset.
- Default build is 4 bits, counting 0..15 and wrapping to 0.
- Used as a generic event/cycle counter and timebase in datapath and control blocks.
- Provides a terminal-count flag and a one-cycle wrap pulse for cascading or for timeout detection.

Parameters:
- WIDTH, 4, bit width of count.
- MAX_VALUE, 2**WIDTH-1, highest value reached before wrapping to 0. Legal range is 1..2**WIDTH-1; other values are an elaboration error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable, sampled on the rising edge of clk.
- count  output  WIDTH  current counter value, registered.
- tc  output  1  terminal count, combinational: 1 when count == MAX_VALUE.
- wrap  output  1  registered pulse: 1 for exactly the cycle following a MAX_VALUE->0 rollover.

Behaviour:
- One clock domain: clk. There are no asynchronous paths.
- Reset:
  - On any rising edge with reset=1, count<=0 and wrap<=0, regardless of enable.
  - tc then follows count, so it is 0 after reset unless MAX_VALUE==0 (which is illegal).
- Priority: reset > enable > hold.
- Enabled increment (rising edge, reset=0, enable=1):
  - If count < MAX_VALUE: count<=count+1 and wrap<=0.
  - If count == MAX_VALUE: count<=0 and wrap<=1.
- Hold (rising edge, reset=0, enable=0): count holds, wrap<=0. wrap never stays high more than one cycle.
- Latency: count reflects an enabled edge immediately after that edge, one cycle per increment. There is no pipeline.
- Arithmetic: unsigned modulo (MAX_VALUE+1). There is no saturation and no down-count.
- Non-power-of-two MAX_VALUE: count never exceeds MAX_VALUE after reset.
- Reset mid-count: the next edge forces 0. A pending wrap is cancelled (wrap=0).
- Reset and enable asserted together: reset wins and count=0.
- Before the first reset edge, count and wrap are undefined. Simulation may show X; no initial value is required.
- enable may toggle every cycle. Each enabled edge adds exactly 1.

Decomposition:
- Shared package holds COUNTER_WIDTH_DEFAULT (4) and a helper function computing the default MAX_VALUE from WIDTH.
- Single flat module; no sub-module is warranted.
- Optional parameter-legality check (assertion at elaboration) lives in the module.

Test Plan:
- Clock period 10 ns, first rising edge at 5 ns. Hold reset=1, enable=0 for 10 ns, then drop reset and raise enable at 10 ns. Required: count=0 after the 5 ns edge, count=1 at 15 ns, then +1 per edge, reaching count=10 after the 105 ns edge. wrap=0 throughout.
- Run enabled from 0 for 16 edges. Required: count reaches 15 with tc=1, the next edge gives count=0, wrap=1 for exactly one cycle, and tc=0.
- At count=7, deassert enable for 3 edges. Required: count stays 7 and wrap=0. Re-enable: the next edge gives count=8.
- At count=12 with enable=1, assert reset for one edge. Required: count=0 on that edge. Release reset with enable=1: the next edge gives count=1.
- At count=15, assert reset and enable together. Required: count=0 and wrap=0 (no wrap pulse).
- Build with WIDTH=4, MAX_VALUE=9 and run 12 enabled edges from reset. Required sequence: 1..9, 0, 1, 2. tc=1 only at count=9; wrap=1 only in the cycle after the 9->0 transition.
